// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and loader feeding a UART transmitter: buffers host bytes and issues one
// ld_tx_data pulse per byte, paced on the transmitter's tx_empty flag.
module uart_tx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              txclk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              load_enable,
    input  logic              tx_empty,
    output logic              ld_tx_data,
    output logic [7:0]        tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              ld_q, ld_d;
    logic [7:0]        txd_q, txd_d;
    logic [7:0]        mem_q [DEPTH];

    logic start, push, pop;

    always_comb begin
        start = (state_q == IDLE) && !empty_q && load_enable && tx_empty && !flush;
        pop   = start;
        // A pop in the same cycle frees the slot the push lands in, even when full.
        push  = wr_en && !flush && (!full_q || pop);

        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = LOAD;
            LOAD:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (!tx_empty) state_d = WAIT_DONE;
            WAIT_DONE: if (tx_empty) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + ADDR_W'(1);
            if (pop)  rptr_d = rptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
            else if (pop && !push) count_d = count_q - (ADDR_W + 1)'(1);
            if (wr_en && full_q && !pop) ovf_d = 1'b1;
        end
        full_d  = (count_d == DepthC);
        empty_d = (count_d == '0);

        txd_d = pop ? mem_q[rptr_q] : txd_q;
        ld_d  = (state_d == LOAD);
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            ld_q    <= 1'b0;
            txd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            ld_q    <= ld_d;
            txd_q   <= txd_d;
        end
    end

    always_ff @(posedge txclk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    assign ld_tx_data = ld_q;
    assign tx_data    = txd_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UART transmitter model on the load interface.
module tb_uart_tx_fifo;

    logic       txclk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       load_enable;
    logic       tx_empty;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .txclk       (txclk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .load_enable (load_enable),
        .tx_empty    (tx_empty),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    // UART model: accepts a load only when idle, then shifts start, 8 data LSB first, stop.
    logic [7:0] loads [$];
    logic       bits [$];
    logic [9:0] sh;
    logic [3:0] bit_cnt;
    int         spurious = 0;

    always @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            tx_empty <= 1'b1;
            bit_cnt  <= 4'd0;
            sh       <= '0;
        end else if (ld_tx_data) begin
            if (!tx_empty) begin
                spurious <= spurious + 1;
            end else begin
                loads.push_back(tx_data);
                sh       <= {1'b1, tx_data, 1'b0};
                bit_cnt  <= 4'd10;
                tx_empty <= 1'b0;
            end
        end else if (bit_cnt != 4'd0) begin
            bits.push_back(sh[0]);
            sh      <= {1'b0, sh[9:1]};
            bit_cnt <= bit_cnt - 4'd1;
        end else if (!tx_empty) begin
            tx_empty <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic wait_loads(input int target, input int budget, input string name);
        int k = 0;
        while (loads.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (loads.size() < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, got %0d loads expected %0d", name, loads.size(), target);
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic [4:0] c;
        logic       f;
        logic       e;
        logic       o;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int         base;
        int         bbase;
        int         k;
        logic [9:0] frame;

        // FIFO bookkeeping with loading disabled: {wr, data, flush, count, full, empty, ovf}
        tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h44, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};

        reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        flush       = 1'b0;
        load_enable = 1'b0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ld", 32'(ld_tx_data), 0);
        check("rst_txdata", 32'(tx_data), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].d;
            flush   = tbl[i].fl;
            tick();
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
            check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].f));
            check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e));
            check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].o));
            check($sformatf("tbl%0d_ld", i), 32'(ld_tx_data), 0);
        end
        wr_en = 1'b0;
        flush = 1'b0;

        // Single byte: latency, frame bits, count returns to 0.
        load_enable = 1'b1;
        base  = loads.size();
        bbase = bits.size();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("single_ld_early", 32'(ld_tx_data), 0);
        check("single_count1", 32'(count), 1);
        tick();
        check("single_ld", 32'(ld_tx_data), 1);
        check("single_txdata", 32'(tx_data), 32'h A5);
        check("single_count0", 32'(count), 0);
        tick();
        check("single_ld_fall", 32'(ld_tx_data), 0);
        repeat (20) tick();
        frame = 'x;
        if (bits.size() >= bbase + 10)
            for (int i = 0; i < 10; i++) frame[i] = bits[bbase + i];
        check("single_frame", 32'(frame), 32'b1101001010);
        check("single_nloads", 32'(loads.size() - base), 1);

        // Burst 01..10 fills the FIFO, then drains in order.
        load_enable = 1'b0;
        base = loads.size();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        check("burst_full", 32'(full), 1);
        check("burst_count", 32'(count), 16);
        check("burst_ovf", 32'(overflow), 0);
        load_enable = 1'b1;
        wait_loads(base + 16, 600, "burst_wait");
        for (int i = 0; i < 16; i++)
            check($sformatf("burst_byte%0d", i), 32'(loads[base + i]), 32'(i + 1));
        repeat (20) tick();
        check("burst_empty", 32'(empty), 1);

        // Overflow: 17th write dropped and sticky until flush.
        load_enable = 1'b0;
        base = loads.size();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        load_enable = 1'b1;
        wait_loads(base + 16, 600, "ovf_wait");
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_byte%0d", i), 32'(loads[base + i]), 32'(8'h20 + i));
        repeat (30) tick();
        check("ovf_nloads", 32'(loads.size() - base), 16);
        check("ovf_sticky", 32'(overflow), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ovf_flush", 32'(overflow), 0);

        // Push and pop in the same cycle while full.
        load_enable = 1'b0;
        base = loads.size();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        wr_data = 8'h99;
        load_enable = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pp_count", 32'(count), 16);
        check("pp_full", 32'(full), 1);
        check("pp_ovf", 32'(overflow), 0);
        check("pp_ld", 32'(ld_tx_data), 1);
        check("pp_txdata", 32'(tx_data), 32'h40);
        wait_loads(base + 17, 700, "pp_wait");
        for (int i = 0; i < 16; i++)
            check($sformatf("pp_byte%0d", i), 32'(loads[base + i]), 32'(8'h40 + i));
        check("pp_last", 32'(loads[base + 16]), 32'h99);
        repeat (20) tick();

        // Flush while the first byte is in WAIT_DONE: it completes, the second is lost.
        base = loads.size();
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        k = 0;
        while (tx_empty && k < 50) begin
            tick();
            k++;
        end
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_empty", 32'(empty), 1);
        check("fl_count", 32'(count), 0);
        repeat (40) tick();
        check("fl_nloads", 32'(loads.size() - base), 1);
        check("fl_byte", 32'(loads[base]), 32'h3C);

        // Asynchronous reset while in LOAD.
        base = loads.size();
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_data = 8'h88;
        tick();
        wr_en = 1'b0;
        check("ar_ld_before", 32'(ld_tx_data), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_ld", 32'(ld_tx_data), 0);
        check("ar_count", 32'(count), 0);
        check("ar_empty", 32'(empty), 1);
        @(negedge txclk);
        reset_n = 1'b1;
        tick();
        wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        check("ar_ld_early", 32'(ld_tx_data), 0);
        tick();
        check("ar_ld_after", 32'(ld_tx_data), 1);
        check("ar_txdata", 32'(tx_data), 32'hC3);
        repeat (20) tick();
        check("ar_nloads", 32'(loads.size() - base), 1);
        check("ar_byte", 32'(loads[base]), 32'hC3);
        check("no_load_while_busy", 32'(spurious), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer and loader that sits directly upstream of the UART transmitter, in the txclk domain. It accepts bytes from the host into a FIFO and feeds the transmitter one byte at a time. Each byte goes out as a single-cycle ld_tx_data pulse with tx_data held stable. The loader paces loads on the transmitter's tx_empty flag, so bytes are never dropped by the transmitter's ignore-when-busy rule.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
txclk  input  1  transmit clock; all logic on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
wr_en  input  1  host write strobe; one byte per cycle while high.
wr_data  input  8  host byte, sampled when wr_en is high.
flush  input  1  synchronous FIFO clear.
load_enable  input  1  when low, no new load is started.
tx_empty  input  1  transmitter idle flag, from the UART.
ld_tx_data  output  1  one-cycle load pulse to the UART.
tx_data  output  8  byte to the UART; stable while ld_tx_data is high.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (reset_n low, asynchronous):
  - count=0, empty=1, full=0, overflow=0.
  - ld_tx_data=0, tx_data=8'h00.
  - Read and write pointers=0; FSM goes to IDLE.
  - Reset mid-transfer discards the FIFO contents and any in-flight byte.
- FIFO storage:
  - Circular buffer of DEPTH x 8 bits; pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - count, full and empty are registered and derived only from the push/pop events of the current cycle.
- Push:
  - A push occurs when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - wr_en=1 with full=1 and no pop: the byte is dropped, overflow is set, and the FIFO is unchanged.
  - overflow clears only on reset or flush.
- Pop: occurs only on the IDLE->LOAD transition.
- Simultaneous push and pop: count is unchanged, both pointers advance. This holds at count=DEPTH (full stays 1) and at any other level.
- Empty FIFO: there is no fall-through. A byte written in cycle N can be popped at the earliest in cycle N+1.
- flush:
  - Clears both pointers, count and overflow in one cycle.
  - Overrides a same-cycle push; the pushed byte is lost.
  - Does not affect the FSM or tx_data; an in-progress load completes.
- FSM, states IDLE, LOAD, WAIT_BUSY, WAIT_DONE:
  - IDLE: go to LOAD when empty=0, load_enable=1, tx_empty=1 and flush=0. On that edge, tx_data <= FIFO head and the pop occurs.
  - LOAD: ld_tx_data=1 for exactly this one cycle. Always go to WAIT_BUSY.
  - WAIT_BUSY: ld_tx_data=0. Go to WAIT_DONE when tx_empty=0, meaning the transmitter accepted the byte.
  - WAIT_DONE: go to IDLE when tx_empty=1, meaning the frame is done.
  - ld_tx_data is a registered output, high if and only if the state is LOAD.
  - tx_data changes only on entry to LOAD.
- Latency: from a write into an empty FIFO with the transmitter idle, ld_tx_data rises 2 cycles later (write at edge N, pop at edge N+1, ld_tx_data high during N+1..N+2).
- Back-to-back bytes: the next load starts no earlier than the first cycle IDLE sees tx_empty=1 after WAIT_DONE. There is at most one outstanding load at any time.
- load_enable low: gates only the IDLE->LOAD transition; an in-flight load is never aborted.
- Stall: if the transmitter's tx_enable is held low, the FSM stays in WAIT_DONE indefinitely. The FIFO keeps accepting writes up to full.

Test Plan:
- Single byte: reset, write 8'hA5 with tx_empty=1 and a UART model attached → one ld_tx_data pulse with tx_data=8'hA5; serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first); count returns to 0.
- Burst: write 8'h01..8'h10 (16 bytes) back-to-back → full=1 after the 16th write; 16 loads in order 01..10, each only after tx_empty has returned high; no overflow.
- Overflow: fill 16 entries with load_enable=0, then write 8'hFF → overflow=1, count=16; enable loading → 16 original bytes out, 8'hFF never sent; flush → overflow=0.
- Full push/pop: at count=16, assert wr_en on the cycle IDLE->LOAD pops → count stays 16, full stays 1, the new byte is sent last.
- Flush mid-transfer: write 8'h3C, 8'h5A; flush during WAIT_DONE of 8'h3C → 8'h3C completes, 8'h5A is never loaded, empty=1.
- Async reset: assert reset_n=0 mid-cycle during LOAD → ld_tx_data drops immediately, count=0, FSM in IDLE; first write after release behaves as in the single-byte case.
